// File: rtl/bootstrap_pkg.sv
// -----------------------------------------------------------------------------
// bootstrap_pkg
// Shared definitions for the microcode bootstrap loader: the loader state
// encoding, the byte width of the boot stream and the minimum number of clock
// cycles spent on each image byte (ACCEPT, SETUP, WRITE, HOLD).
// -----------------------------------------------------------------------------
package bootstrap_pkg;

  localparam int BYTE_W          = 8;
  localparam int CYCLES_PER_BYTE = 4;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    SETUP,
    WRITE,
    HOLD,
    CHECK,
    DONE,
    ERROR
  } state_e;

endpackage

// File: rtl/boot_addr_counter.sv
// -----------------------------------------------------------------------------
// boot_addr_counter
// Microcode store write address counter.
// Ports:
//   clk_i   in   clock (rising edge)
//   rst_ni  in   async active-low reset, clears the address
//   clr_i   in   synchronous load-zero
//   inc_i   in   synchronous increment (ignored when clr_i is high)
//   addr_o  out  current address (registered)
//   tc_o    out  terminal count: address is all ones
// -----------------------------------------------------------------------------
module boot_addr_counter #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  tc_o
);

  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else if (clr_i) begin
      addr_q <= '0;
    end else if (inc_i) begin
      addr_q <= addr_q + ADDR_WIDTH'(1);
    end
  end

  assign addr_o = addr_q;
  assign tc_o   = &addr_q;

endmodule

// File: rtl/bootstrap_loader.sv
// -----------------------------------------------------------------------------
// bootstrap_loader
// Streams a 2^ADDR_WIDTH byte microcode image from a valid/ready boot source
// into the microcode store, one byte every four cycles minimum, then releases
// the control path reset.
// Optional feature: define BOOTSTRAP_CHECKSUM_EN to require a trailing checksum
// byte; the modulo-256 sum of image and checksum must be zero, otherwise the
// loader parks in ERROR with BOOT_ERR set.
// Ports:
//   N_CLK           in   clock, rising edge
//   N_RST           in   async active-low reset
//   START           in   level, begins a load from IDLE
//   IN_DATA         in   image byte
//   IN_VALID        in   IN_DATA valid
//   IN_READY        out  loader accepts a byte this cycle
//   BOOTSTRAP_ADDR  out  microcode store write address
//   BOOTSTRAP_DATA  out  microcode store write data
//   BOOTSTRAP_N_WE  out  active-low write strobe (registered)
//   N_BOOTED        out  low once the image is loaded
//   SYS_N_RST       out  control path reset, rises one cycle after N_BOOTED falls
//   BOOT_ERR        out  checksum failure
// -----------------------------------------------------------------------------
module bootstrap_loader
  import bootstrap_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  N_CLK,
  input  logic                  N_RST,
  input  logic                  START,
  input  logic [BYTE_W-1:0]     IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [ADDR_WIDTH-1:0] BOOTSTRAP_ADDR,
  output logic [BYTE_W-1:0]     BOOTSTRAP_DATA,
  output logic                  BOOTSTRAP_N_WE,
  output logic                  N_BOOTED,
  output logic                  SYS_N_RST,
  output logic                  BOOT_ERR
);

  state_e              state_q;
  logic [BYTE_W-1:0]   data_q;
  logic                n_we_q;
  logic                n_booted_q;
  logic                sys_n_rst_q;
  logic                in_ready_q;
  logic                addr_clr;
  logic                addr_inc;
  logic                addr_tc;
  logic                hs_accept;

  // Outputs are registered together with the state, so each one is set on the
  // same edge that enters the state it belongs to.
  assign hs_accept = (state_q == ACCEPT) && IN_VALID && in_ready_q;
  assign addr_clr  = (state_q == IDLE) && START;
  assign addr_inc  = (state_q == HOLD) && !addr_tc;

  boot_addr_counter #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_cnt (
    .clk_i  (N_CLK),
    .rst_ni (N_RST),
    .clr_i  (addr_clr),
    .inc_i  (addr_inc),
    .addr_o (BOOTSTRAP_ADDR),
    .tc_o   (addr_tc)
  );

`ifdef BOOTSTRAP_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;
  logic [BYTE_W-1:0] csum_total;
  logic              boot_err_q;
  logic              hs_check;

  assign hs_check   = (state_q == CHECK) && IN_VALID && in_ready_q;
  assign csum_total = csum_q + IN_DATA;

  always_ff @(posedge N_CLK or negedge N_RST) begin
    if (!N_RST) begin
      csum_q <= '0;
    end else if (hs_accept) begin
      csum_q <= csum_total;
    end
  end

  assign BOOT_ERR = boot_err_q;
`else
  assign BOOT_ERR = 1'b0;
`endif

  always_ff @(posedge N_CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q     <= IDLE;
      data_q      <= '0;
      n_we_q      <= 1'b1;
      n_booted_q  <= 1'b1;
      sys_n_rst_q <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef BOOTSTRAP_CHECKSUM_EN
      boot_err_q  <= 1'b0;
`endif
    end else begin
      // Follows N_BOOTED by one cycle; stays low in ERROR since N_BOOTED does.
      sys_n_rst_q <= ~n_booted_q;
      unique case (state_q)
        IDLE: begin
          if (START) begin
            state_q    <= ACCEPT;
            in_ready_q <= 1'b1;
          end
        end
        ACCEPT: begin
          if (hs_accept) begin
            data_q     <= IN_DATA;
            in_ready_q <= 1'b0;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          n_we_q  <= 1'b0;
          state_q <= WRITE;
        end
        WRITE: begin
          n_we_q  <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          if (!addr_tc) begin
            in_ready_q <= 1'b1;
            state_q    <= ACCEPT;
          end else begin
`ifdef BOOTSTRAP_CHECKSUM_EN
            in_ready_q <= 1'b1;
            state_q    <= CHECK;
`else
            n_booted_q <= 1'b0;
            state_q    <= DONE;
`endif
          end
        end
`ifdef BOOTSTRAP_CHECKSUM_EN
        CHECK: begin
          if (hs_check) begin
            in_ready_q <= 1'b0;
            if (csum_total == '0) begin
              n_booted_q <= 1'b0;
              state_q    <= DONE;
            end else begin
              boot_err_q <= 1'b1;
              state_q    <= ERROR;
            end
          end
        end
`endif
        // DONE and ERROR are terminal until reset.
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign IN_READY       = in_ready_q;
  assign BOOTSTRAP_DATA = data_q;
  assign BOOTSTRAP_N_WE = n_we_q;
  assign N_BOOTED       = n_booted_q;
  assign SYS_N_RST      = sys_n_rst_q;

endmodule

// File: doc/bootstrap_loader.md
BOOTSTRAP_LOADER -- requirements
Module: bootstrap_loader

Interface
REQ-001 SHALL have parameter: ADDR_WIDTH, 12, microcode image address width; image size is 2^ADDR_WIDTH bytes.
REQ-002 SHALL use reset N_RST, asynchronous, active-low; clock N_CLK.
REQ-003 SHALL have port: N_CLK  in  1  clock; all state changes on rising N_CLK.
REQ-004 SHALL have port: N_RST  in  1  async active-low reset.
REQ-005 SHALL have port: START  in  1  level; begins a load from IDLE.
REQ-006 SHALL have port: IN_DATA  in  8  image byte from the boot source.
REQ-007 SHALL have port: IN_VALID  in  1  IN_DATA valid.
REQ-008 SHALL have port: IN_READY  out  1  loader accepts a byte this cycle.
REQ-009 SHALL have port: BOOTSTRAP_ADDR  out  ADDR_WIDTH  microcode store write address.
REQ-010 SHALL have port: BOOTSTRAP_DATA  out  8  microcode store write data.
REQ-011 SHALL have port: BOOTSTRAP_N_WE  out  1  active-low write strobe.
REQ-012 SHALL have port: N_BOOTED  out  1  low once the image is loaded (enables microcode store output).
REQ-013 SHALL have port: SYS_N_RST  out  1  active-low reset to the control path; held low until booted.
REQ-014 SHALL have port: BOOT_ERR  out  1  checksum failure flag.

Function
REQ-015 SHALL implement states IDLE, ACCEPT, SETUP, WRITE, HOLD, CHECK, DONE, ERROR.
REQ-016 SHALL move IDLE->ACCEPT on START=1; in all other states, START is ignored.
REQ-017 SHALL drive IN_READY=1 only in ACCEPT (and in CHECK, when checksum is enabled).
REQ-018 SHALL treat a handshake as IN_VALID&IN_READY on a rising edge; ACCEPT waits indefinitely without a handshake.
REQ-019 SHALL, on an ACCEPT handshake, latch IN_DATA into BOOTSTRAP_DATA and go to SETUP.
REQ-020 SHALL sequence SETUP->WRITE->HOLD, one cycle each, with BOOTSTRAP_N_WE=0 only in WRITE.
REQ-021 SHALL drive BOOTSTRAP_N_WE from a register (glitch-free), with ADDR/DATA stable across SETUP, WRITE and HOLD.
REQ-022 SHALL, on leaving HOLD, increment BOOTSTRAP_ADDR and go to ACCEPT, unless the address equals 2^ADDR_WIDTH-1.
REQ-023 SHALL, at the last address, leave HOLD to CHECK when checksum is enabled, otherwise to DONE; the address SHALL NOT wrap.
REQ-024 SHALL give a minimum cost of 4 cycles per byte with IN_VALID held high.
REQ-025 SHALL, in DONE, set N_BOOTED=0, hold BOOTSTRAP_N_WE=1 and IN_READY=0 permanently until reset, and ignore IN_VALID.
REQ-026 SHALL register SYS_N_RST so it rises on the cycle after N_BOOTED falls.
REQ-027 SHALL never have N_BOOTED=0 and BOOTSTRAP_N_WE=0 simultaneously.
REQ-028 SHALL, in ERROR, set BOOT_ERR=1, N_BOOTED=1, SYS_N_RST=0 and BOOTSTRAP_N_WE=1 until reset.

Reset
REQ-029 SHALL, on N_RST=0, immediately (asynchronously) enter IDLE with BOOTSTRAP_ADDR=0, BOOTSTRAP_DATA=0, BOOTSTRAP_N_WE=1, N_BOOTED=1, SYS_N_RST=0, IN_READY=0, BOOT_ERR=0, checksum accumulator=0.
REQ-030 SHALL abort any load in progress on reset, including mid-WRITE; the next load restarts at address 0.

Configuration
REQ-031 SHALL, with BOOTSTRAP_CHECKSUM_EN defined, accumulate an 8-bit modulo-256 sum of all image bytes plus one trailing checksum byte accepted in CHECK; a total of 0x00 goes to DONE, any other value goes to ERROR.
REQ-032 SHALL, without BOOTSTRAP_CHECKSUM_EN, omit CHECK and the accumulator and tie BOOT_ERR to 0.

Structure
REQ-033 SHALL place the state enum, byte width (8) and per-byte cycle count (4) in shared package bootstrap_pkg.
REQ-034 SHALL implement the address counter as sub-module boot_addr_counter (load-zero, increment, terminal-count output).

Verification (ADDR_WIDTH=2)
REQ-035 SHALL verify: reset asserted mid-sim -> all outputs at REQ-029 values within the same timestep.
REQ-036 SHALL verify: START, then bytes 11,22,33,44 with IN_VALID=1 -> N_WE pulses at addr 0..3 with matching data; N_BOOTED=0 16 cycles after the first handshake; SYS_N_RST=1 one cycle later.
REQ-037 SHALL verify: IN_VALID low for 5 cycles between bytes -> loader stays in ACCEPT, no N_WE pulse, addr unchanged.
REQ-038 SHALL verify: N_RST pulsed after 2 bytes, then restart -> writes resume from addr 0 with new data.
REQ-039 SHALL verify, with checksum enabled: bytes 11,22,33,44 plus checksum 56 -> DONE; plus checksum 57 -> BOOT_ERR=1, N_BOOTED=1.
REQ-040 SHALL verify: after DONE, IN_VALID=1 and START=1 for 10 cycles -> IN_READY=0, no N_WE pulse.
